// File: rtl/startup_sequencer.sv
// Multi-channel start-up sequencer: waits for generator/checker/lock to be stable,
// then raises per-channel start enables one slot at a time and counts lock-loss aborts.
module startup_sequencer #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DELAY_W     = 8,
  parameter int unsigned START_DELAY = 9,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              tx_clk_i,
  input  logic              rst_n_i,
  input  logic              pattern_gen_n_i,
  input  logic              pattern_chk_n_i,
  input  logic              lock_i,
  input  logic              restart_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic [NUM_CH-1:0] start_gen_o,
  output logic              all_started_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  fault_cnt_o
);

  localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [DELAY_W-1:0] WaitLast = DELAY_W'(START_DELAY - 1);
  localparam logic [DELAY_W-1:0] GapLast  = DELAY_W'(STAGE_GAP - 1);
  localparam logic [IdxW-1:0]    IdxLast  = IdxW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StStagger = 2'd2,
    StRun     = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DELAY_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0]   reached_q, reached_d;
  logic [NUM_CH-1:0]   start_q, start_d;
  logic                all_q, all_d;
  logic [CNT_W-1:0]    fault_q, fault_d;
  logic                ok;

  assign ok = pattern_gen_n_i & pattern_chk_n_i & lock_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    reached_d = reached_q;
    all_d     = all_q;
    fault_d   = fault_q;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        idx_d     = '0;
        reached_d = '0;
        all_d     = 1'b0;
        if (ok) begin
          if (START_DELAY == 1) begin
            state_d      = StStagger;
            reached_d[0] = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = DELAY_W'(1);
          end
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) begin
          state_d      = StStagger;
          cnt_d        = '0;
          reached_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + DELAY_W'(1);
        end
      end
      StStagger: begin
        // Every index consumes its slot regardless of mask, so timing is mask-independent.
        if (idx_q == IdxLast) begin
          state_d = StRun;
          all_d   = 1'b1;
        end else if (cnt_q == GapLast) begin
          idx_d            = idx_q + IdxW'(1);
          reached_d[idx_d] = 1'b1;
          cnt_d            = '0;
        end else begin
          cnt_d = cnt_q + DELAY_W'(1);
        end
      end
      StRun: begin
        if (restart_i) begin
          state_d   = StIdle;
          cnt_d     = '0;
          idx_d     = '0;
          reached_d = '0;
          all_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides restart and any progress made this edge.
    if (state_q != StIdle && !ok) begin
      state_d   = StIdle;
      cnt_d     = '0;
      idx_d     = '0;
      reached_d = '0;
      all_d     = 1'b0;
      if (!lock_i && (state_q == StStagger || state_q == StRun) && fault_q != '1) begin
        fault_d = fault_q + CNT_W'(1);
      end
    end

    start_d = reached_d & ch_mask_i;
  end

  always_ff @(posedge tx_clk_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      reached_q <= '0;
      start_q   <= '0;
      all_q     <= 1'b0;
      fault_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      reached_q <= reached_d;
      start_q   <= start_d;
      all_q     <= all_d;
      fault_q   <= fault_d;
    end
  end

  assign start_gen_o   = start_q;
  assign all_started_o = all_q;
  assign state_o       = state_q;
  assign fault_cnt_o   = fault_q;

endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: two parameterisations driven in lockstep and compared
// every cycle against an edge-count reference model.
module tb_startup_sequencer;

  localparam int unsigned NCh = 4;

  logic           tx_clk = 1'b0;
  logic           rst_n, gen_n, chk_n, lock, restart;
  logic [NCh-1:0] mask;

  logic [NCh-1:0] sg_a, sg_b;
  logic           all_a, all_b;
  logic [1:0]     st_a, st_b;
  logic [7:0]     fc_a;
  logic [1:0]     fc_b;

  always #5 tx_clk = ~tx_clk;

  startup_sequencer u_dut_a (
    .tx_clk_i        (tx_clk),
    .rst_n_i         (rst_n),
    .pattern_gen_n_i (gen_n),
    .pattern_chk_n_i (chk_n),
    .lock_i          (lock),
    .restart_i       (restart),
    .ch_mask_i       (mask),
    .start_gen_o     (sg_a),
    .all_started_o   (all_a),
    .state_o         (st_a),
    .fault_cnt_o     (fc_a)
  );

  startup_sequencer #(
    .NUM_CH      (NCh),
    .DELAY_W     (8),
    .START_DELAY (1),
    .STAGE_GAP   (1),
    .CNT_W       (2)
  ) u_dut_b (
    .tx_clk_i        (tx_clk),
    .rst_n_i         (rst_n),
    .pattern_gen_n_i (gen_n),
    .pattern_chk_n_i (chk_n),
    .lock_i          (lock),
    .restart_i       (restart),
    .ch_mask_i       (mask),
    .start_gen_o     (sg_b),
    .all_started_o   (all_b),
    .state_o         (st_b),
    .fault_cnt_o     (fc_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Model: m_e is the edge number within the current sequence (0 = idle).
  int unsigned    m_e[2]     = '{0, 0};
  int unsigned    m_fault[2] = '{0, 0};
  int unsigned    p_sd[2]    = '{9, 1};
  int unsigned    p_gap[2]   = '{4, 1};
  int unsigned    p_fmax[2]  = '{255, 3};
  logic [NCh-1:0] exp_sg[2];
  logic           exp_all[2];
  int unsigned    exp_st[2];

  function automatic int unsigned run_edge(input int k);
    return p_sd[k] + (NCh - 1) * p_gap[k] + 1;
  endfunction

  task automatic model_step(input int k);
    logic ok;
    ok = gen_n & chk_n & lock;
    if (!rst_n) begin
      m_e[k]     = 0;
      m_fault[k] = 0;
    end else if (m_e[k] == 0) begin
      if (ok) m_e[k] = 1;
    end else if (!ok) begin
      if (!lock && m_e[k] >= p_sd[k] && m_fault[k] < p_fmax[k]) m_fault[k]++;
      m_e[k] = 0;
    end else if (m_e[k] >= run_edge(k)) begin
      if (restart) m_e[k] = 0;
    end else begin
      m_e[k]++;
    end
    for (int i = 0; i < NCh; i++)
      exp_sg[k][i] = (m_e[k] != 0) && (m_e[k] >= p_sd[k] + i * p_gap[k]) && mask[i];
    exp_all[k] = (m_e[k] >= run_edge(k));
    if (m_e[k] == 0)                exp_st[k] = 0;
    else if (m_e[k] < p_sd[k])      exp_st[k] = 1;
    else if (m_e[k] >= run_edge(k)) exp_st[k] = 3;
    else                            exp_st[k] = 2;
  endtask

  task automatic step();
    @(posedge tx_clk);
    model_step(0);
    model_step(1);
    #1;
    check("a_start_gen", sg_a, exp_sg[0]);
    check("a_all_started", all_a, exp_all[0]);
    check("a_state", st_a, exp_st[0]);
    check("a_fault_cnt", fc_a, m_fault[0]);
    check("b_start_gen", sg_b, exp_sg[1]);
    check("b_all_started", all_b, exp_all[1]);
    check("b_state", st_b, exp_st[1]);
    check("b_fault_cnt", fc_b, m_fault[1]);
  endtask

  initial begin
    rst_n   = 1'b0;
    gen_n   = 1'b1;
    chk_n   = 1'b1;
    lock    = 1'b1;
    restart = 1'b0;
    mask    = 4'b1111;
    repeat (2) step();
    check("reset_sg_a", sg_a, 0);
    check("reset_fc_a", fc_a, 0);
    check("reset_state_a", st_a, 0);

    // Plain sequence with all channels enabled; spot-check the documented edges.
    rst_n = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      step();
      if (e == 9)  check("dir_a_ch0_edge9", sg_a, 4'b0001);
      if (e == 17) check("dir_a_ch2_edge17", sg_a, 4'b0111);
      if (e == 21) check("dir_a_all_edge21", {all_a, sg_a}, 5'b0_1111);
      if (e == 22) check("dir_a_run_edge22", {all_a, st_a}, 3'b1_11);
      if (e == 3)  check("dir_b_edge3", sg_b, 4'b0111);
    end

    // Repeated lock drops in RUN drive the 2-bit counter into saturation.
    for (int d = 0; d < 5; d++) begin
      lock = 1'b0;
      step();
      lock = 1'b1;
      repeat (24) step();
    end
    check("dir_b_fault_sat", fc_b, 3);
    check("dir_a_fault_5", fc_a, 5);

    for (int c = 0; c < 4000; c++) begin
      rst_n   = ($urandom_range(0, 399) != 0);
      gen_n   = ($urandom_range(0, 199) != 0);
      chk_n   = ($urandom_range(0, 199) != 0);
      lock    = ($urandom_range(0, 99) != 0);
      restart = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 19) == 0) mask = NCh'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
